// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - timing configuration type, defaults and legality check
package video_timing_pkg;

  localparam int VT_CNT_W = 12;

  typedef struct packed {
    logic [VT_CNT_W-1:0] h_active;
    logic [VT_CNT_W-1:0] h_fp;
    logic [VT_CNT_W-1:0] h_sync;
    logic [VT_CNT_W-1:0] h_bp;
    logic [VT_CNT_W-1:0] v_active;
    logic [VT_CNT_W-1:0] v_fp;
    logic [VT_CNT_W-1:0] v_sync;
    logic [VT_CNT_W-1:0] v_bp;
    logic                hs_pol;
    logic                vs_pol;
  } timing_cfg_t;

  localparam timing_cfg_t DEF_CFG = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd29,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam logic [VT_CNT_W+1:0] MAX_TOTAL = (VT_CNT_W+2)'(1) << VT_CNT_W;

  function automatic logic [VT_CNT_W+1:0] axis_total(input logic [VT_CNT_W-1:0] a, f, s, b);
    return {2'b00, a} + {2'b00, f} + {2'b00, s} + {2'b00, b};
  endfunction

  // A total of exactly 2^CNT_W still fits: the counter tops out at all-ones.
  function automatic logic cfg_legal(input timing_cfg_t c);
    logic nonzero;
    nonzero = (c.h_active != '0) && (c.h_fp != '0) && (c.h_sync != '0) && (c.h_bp != '0) &&
              (c.v_active != '0) && (c.v_fp != '0) && (c.v_sync != '0) && (c.v_bp != '0);
    return nonzero &&
           (axis_total(c.h_active, c.h_fp, c.h_sync, c.h_bp) <= MAX_TOTAL) &&
           (axis_total(c.v_active, c.v_fp, c.v_sync, c.v_bp) <= MAX_TOTAL);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_cnt.sv
// rtl/video_timing_gen_axis_cnt.sv - one timing axis: wrapping counter plus window decode
module timing_axis_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic [W-1:0] active,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  input  logic [W-1:0] bp,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         act,
  output logic         sync_win
);

  logic [W+1:0] c_ext;
  logic [W+1:0] sync_start;
  logic [W+1:0] sync_end;
  logic [W+1:0] total;

  assign c_ext      = {2'b00, cnt};
  assign sync_start = {2'b00, active} + {2'b00, fp};
  assign sync_end   = sync_start + {2'b00, sync};
  assign total      = sync_end + {2'b00, bp};

  // wrap marks the last count of the period, independent of step
  assign wrap     = (c_ext == total - (W+2)'(1));
  assign act      = (c_ext < {2'b00, active});
  assign sync_win = (c_ext >= sync_start) && (c_ext < sync_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-reconfigurable video timing generator
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   CNT_W        = 12,
  parameter int   DEF_H_ACTIVE = 640,
  parameter int   DEF_H_FP     = 16,
  parameter int   DEF_H_SYNC   = 96,
  parameter int   DEF_H_BP     = 48,
  parameter int   DEF_V_ACTIVE = 480,
  parameter int   DEF_V_FP     = 10,
  parameter int   DEF_V_SYNC   = 2,
  parameter int   DEF_V_BP     = 29,
  parameter logic DEF_HS_POL   = 1'b0,
  parameter logic DEF_VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  timing_cfg_t      i_cfg,
  output logic             o_cfg_err,
  output logic             o_pix_valid,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_sol,
  output logic             o_sof,
  output logic             o_eof
);

  localparam timing_cfg_t RST_CFG = '{
    h_active: VT_CNT_W'(DEF_H_ACTIVE), h_fp: VT_CNT_W'(DEF_H_FP),
    h_sync:   VT_CNT_W'(DEF_H_SYNC),   h_bp: VT_CNT_W'(DEF_H_BP),
    v_active: VT_CNT_W'(DEF_V_ACTIVE), v_fp: VT_CNT_W'(DEF_V_FP),
    v_sync:   VT_CNT_W'(DEF_V_SYNC),   v_bp: VT_CNT_W'(DEF_V_BP),
    hs_pol: DEF_HS_POL, vs_pol: DEF_VS_POL
  };

  timing_cfg_t      cfg_act;
  timing_cfg_t      cfg_pend;
  logic             pend;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_wrap, h_act, h_sw;
  logic             v_wrap, v_act, v_sw;
  logic             frame_end;
  logic             xfer;
  logic             apply;

  timing_axis_cnt #(.W(CNT_W)) u_h (
    .clk(clk), .rst(rst), .step(i_en),
    .active(cfg_act.h_active), .fp(cfg_act.h_fp), .sync(cfg_act.h_sync), .bp(cfg_act.h_bp),
    .cnt(hcnt), .wrap(h_wrap), .act(h_act), .sync_win(h_sw)
  );

  timing_axis_cnt #(.W(CNT_W)) u_v (
    .clk(clk), .rst(rst), .step(i_en && h_wrap),
    .active(cfg_act.v_active), .fp(cfg_act.v_fp), .sync(cfg_act.v_sync), .bp(cfg_act.v_bp),
    .cnt(vcnt), .wrap(v_wrap), .act(v_act), .sync_win(v_sw)
  );

  assign frame_end   = h_wrap && v_wrap;
  assign o_cfg_ready = !pend;
  assign xfer        = i_cfg_valid && !pend;
  // apply needs pend already set, so it can never coincide with a transfer
  assign apply       = i_en && frame_end && pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_act   <= RST_CFG;
      cfg_pend  <= RST_CFG;
      pend      <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= xfer && !cfg_legal(i_cfg);
      if (apply) begin
        cfg_act <= cfg_pend;
        pend    <= 1'b0;
      end else if (xfer && cfg_legal(i_cfg)) begin
        cfg_pend <= i_cfg;
        pend     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_col       <= '0;
      o_row       <= '0;
      o_pix_valid <= 1'b0;
      o_hsync     <= ~DEF_HS_POL;
      o_vsync     <= ~DEF_VS_POL;
      o_sol       <= 1'b0;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
    end else if (i_en) begin
      o_col       <= hcnt;
      o_row       <= vcnt;
      o_pix_valid <= h_act && v_act;
      o_hsync     <= h_sw ? cfg_act.hs_pol : ~cfg_act.hs_pol;
      o_vsync     <= v_sw ? cfg_act.vs_pol : ~cfg_act.vs_pol;
      o_sol       <= (hcnt == '0);
      o_sof       <= (hcnt == '0) && (vcnt == '0);
      o_eof       <= frame_end;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct {
    logic [11:0] col;
    logic [11:0] row;
    logic pv, hs, vs, sol, sof, eof, err, rdy, adv;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] got;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  logic i_en, i_cfg_valid;
  timing_cfg_t i_cfg;
  logic o_cfg_ready, o_cfg_err, o_pix_valid, o_hsync, o_vsync, o_sol, o_sof, o_eof;
  logic [11:0] o_col, o_row;
  logic d_cfg_ready, d_cfg_err, d_pix_valid, d_hsync, d_vsync, d_sol, d_sof, d_eof;
  logic [11:0] d_col, d_row;
  timing_cfg_t d_cfg;

  always #5 clk = ~clk;

  // small reset timing keeps whole frames cheap: 16x8 total, 8x4 active
  video_timing_gen #(
    .DEF_H_ACTIVE(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(3),
    .DEF_V_ACTIVE(4), .DEF_V_FP(1), .DEF_V_SYNC(2), .DEF_V_BP(1),
    .DEF_HS_POL(1'b0), .DEF_VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg(i_cfg), .o_cfg_err(o_cfg_err), .o_pix_valid(o_pix_valid), .o_col(o_col),
    .o_row(o_row), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_sol(o_sol), .o_sof(o_sof),
    .o_eof(o_eof)
  );

  video_timing_gen dut_def (
    .clk(clk), .rst(rst), .i_en(1'b1), .i_cfg_valid(1'b0), .o_cfg_ready(d_cfg_ready),
    .i_cfg(d_cfg), .o_cfg_err(d_cfg_err), .o_pix_valid(d_pix_valid), .o_col(d_col),
    .o_row(d_row), .o_hsync(d_hsync), .o_vsync(d_vsync), .o_sol(d_sol), .o_sof(d_sof),
    .o_eof(d_eof)
  );

  exp_t sb_q[$];
  chk_t chk_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_h, m_v;
  logic m_pend;
  timing_cfg_t m_cfg, m_pcfg;
  exp_t m_last;

  int fr_cnt, err_cnt, fin_pv, fin_cyc, fin_lines;
  logic [15:0] fin_hs, fin_vs;

  function automatic timing_cfg_t mk_cfg(input int ha, hf, hs, hb, va, vf, vs, vb,
                                         input logic hp, vp);
    timing_cfg_t c;
    c.h_active = 12'(ha); c.h_fp = 12'(hf); c.h_sync = 12'(hs); c.h_bp = 12'(hb);
    c.v_active = 12'(va); c.v_fp = 12'(vf); c.v_sync = 12'(vs); c.v_bp = 12'(vb);
    c.hs_pol = hp; c.vs_pol = vp;
    return c;
  endfunction

  function automatic logic [33:0] pk(input logic [11:0] col, row,
                                     input logic pv, hs, vs, sol, sof, eof, err, rdy);
    return {col, row, pv, hs, vs, sol, sof, eof, err, rdy};
  endfunction

  function automatic int tot_h(input timing_cfg_t c);
    return int'(c.h_active) + int'(c.h_fp) + int'(c.h_sync) + int'(c.h_bp);
  endfunction

  function automatic int tot_v(input timing_cfg_t c);
    return int'(c.v_active) + int'(c.v_fp) + int'(c.v_sync) + int'(c.v_bp);
  endfunction

  function automatic logic bench_legal(input timing_cfg_t c);
    if (c.h_active == 0 || c.h_fp == 0 || c.h_sync == 0 || c.h_bp == 0) return 1'b0;
    if (c.v_active == 0 || c.v_fp == 0 || c.v_sync == 0 || c.v_bp == 0) return 1'b0;
    return (tot_h(c) <= 4096) && (tot_v(c) <= 4096);
  endfunction

  localparam logic [33:0] RST_VEC = {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  timing_cfg_t SMALL_DEF, C1, C2, BAD;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_pend = 1'b0;
    m_cfg = SMALL_DEF; m_pcfg = SMALL_DEF;
    m_last = '{col: 12'd0, row: 12'd0, pv: 1'b0, hs: 1'b1, vs: 1'b1, sol: 1'b0,
               sof: 1'b0, eof: 1'b0, err: 1'b0, rdy: 1'b1, adv: 1'b0};
  endtask

  task automatic expect_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_q.push_back('{name: name, got: got, exp: exp});
  endtask

  task automatic tick(input logic en, input logic v, input timing_cfg_t c);
    exp_t e;
    int ht, vt, ha, hw0, hw1, va, vw0, vw1;
    logic xfer, ok;
    @(negedge clk);
    i_en = en; i_cfg_valid = v; i_cfg = c;
    ht = tot_h(m_cfg); vt = tot_v(m_cfg);
    ha = int'(m_cfg.h_active); hw0 = ha + int'(m_cfg.h_fp); hw1 = hw0 + int'(m_cfg.h_sync);
    va = int'(m_cfg.v_active); vw0 = va + int'(m_cfg.v_fp); vw1 = vw0 + int'(m_cfg.v_sync);
    e = m_last;
    ok = bench_legal(c);
    xfer = v && !m_pend;
    e.err = xfer && !ok;
    e.adv = en;
    if (en) begin
      e.col = 12'(m_h); e.row = 12'(m_v);
      e.pv  = (m_h < ha) && (m_v < va);
      e.hs  = (m_h >= hw0 && m_h < hw1) ? m_cfg.hs_pol : !m_cfg.hs_pol;
      e.vs  = (m_v >= vw0 && m_v < vw1) ? m_cfg.vs_pol : !m_cfg.vs_pol;
      e.sol = (m_h == 0);
      e.sof = (m_h == 0) && (m_v == 0);
      e.eof = (m_h == ht - 1) && (m_v == vt - 1);
    end
    if (en && m_pend && m_h == ht - 1 && m_v == vt - 1) begin
      m_cfg = m_pcfg; m_pend = 1'b0;
    end
    if (xfer && ok) begin
      m_pcfg = c; m_pend = 1'b1;
    end
    if (en) begin
      if (m_h == ht - 1) begin
        m_h = 0;
        m_v = (m_v == vt - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    e.rdy = !m_pend;
    m_last = e;
    sb_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b1, 1'b0, C1);
  endtask

  task automatic run_until(input int h, input int v);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (m_h == h && m_v == v) break;
      tick(1'b1, 1'b0, C1);
    end
    if (k == 2000) expect_eq("run_until_timeout", 64'd0, 64'd1);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic check_frame(input string tag, input int cyc, input int pv, input int lines,
                             input logic [15:0] hs, input logic [15:0] vs);
    expect_eq({tag, "_cycles"}, 64'(fin_cyc), 64'(cyc));
    expect_eq({tag, "_pix"}, 64'(fin_pv), 64'(pv));
    expect_eq({tag, "_lines"}, 64'(fin_lines), 64'(lines));
    expect_eq({tag, "_hs_cols"}, 64'(fin_hs), 64'(hs));
    expect_eq({tag, "_vs_rows"}, 64'(fin_vs), 64'(vs));
  endtask

  // monitor: pops one expected record per presented DUT output and keeps frame statistics
  initial begin
    exp_t e;
    chk_t k;
    logic [33:0] got, want;
    logic started;
    int cur_pv, cur_cyc, cur_lines;
    logic [15:0] cur_hs, cur_vs;
    started = 1'b0; fr_cnt = 0; err_cnt = 0;
    cur_pv = 0; cur_cyc = 0; cur_lines = 0; cur_hs = '0; cur_vs = '0;
    fin_pv = 0; fin_cyc = 0; fin_lines = 0; fin_hs = '0; fin_vs = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        started = 1'b0; fr_cnt = 0; err_cnt = 0;
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got  = pk(o_col, o_row, o_pix_valid, o_hsync, o_vsync, o_sol, o_sof, o_eof,
                  o_cfg_err, o_cfg_ready);
        want = pk(e.col, e.row, e.pv, e.hs, e.vs, e.sol, e.sof, e.eof, e.err, e.rdy);
        n_checks++;
        if (got !== want) begin
          n_errors++;
          $display("FAIL timing @%0t: got %h required %h (col %0d row %0d)",
                   $time, got, want, e.col, e.row);
        end
        if (o_cfg_err) err_cnt++;
        if (e.adv) begin
          if (o_sof) begin
            if (started) begin
              fin_pv = cur_pv; fin_cyc = cur_cyc; fin_lines = cur_lines;
              fin_hs = cur_hs; fin_vs = cur_vs; fr_cnt++;
            end
            started = 1'b1;
            cur_pv = 0; cur_cyc = 0; cur_lines = 0; cur_hs = '0; cur_vs = '0;
          end
          if (started) begin
            cur_cyc++;
            if (o_pix_valid) cur_pv++;
            if (o_sol) cur_lines++;
            if (o_hsync && o_col < 12'd16) cur_hs[o_col[3:0]] = 1'b1;
            if (o_vsync && o_row < 12'd16) cur_vs[o_row[3:0]] = 1'b1;
          end
        end
      end
      while (chk_q.size() > 0) begin
        k = chk_q.pop_front();
        n_checks++;
        if (k.got !== k.exp) begin
          n_errors++;
          $display("FAIL %s: got %0d required %0d", k.name, k.got, k.exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, hs_low, pv_cnt, first_low, last_low;
    SMALL_DEF = mk_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0);
    C1  = mk_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    C2  = mk_cfg(5, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    BAD = mk_cfg(4, 1, 0, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    d_cfg = '0;
    rst = 1'b1; i_en = 1'b0; i_cfg_valid = 1'b0; i_cfg = C1;
    model_reset();
    repeat (3) @(negedge clk);
    expect_eq("reset_main", 64'(pk(o_col, o_row, o_pix_valid, o_hsync, o_vsync, o_sol, o_sof,
                                   o_eof, o_cfg_err, o_cfg_ready)), 64'(RST_VEC));
    expect_eq("reset_default", 64'(pk(d_col, d_row, d_pix_valid, d_hsync, d_vsync, d_sol, d_sof,
                                      d_eof, d_cfg_err, d_cfg_ready)), 64'(RST_VEC));
    rst = 1'b0;

    // default 640x480 instance: first line shape
    s0 = -1; s1 = -1; hs_low = 0; pv_cnt = 0; first_low = -1; last_low = -1;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #3;
      if (d_sol) begin
        if (s0 < 0) s0 = i;
        else if (s1 < 0) s1 = i;
      end
      if (s0 >= 0 && s1 < 0) begin
        if (!d_hsync) begin
          hs_low++;
          if (first_low < 0) first_low = int'(d_col);
          last_low = int'(d_col);
        end
        if (d_pix_valid) pv_cnt++;
      end
    end
    expect_eq("def_line_len", 64'(s1 - s0), 64'd800);
    expect_eq("def_hs_width", 64'(hs_low), 64'd96);
    expect_eq("def_hs_first", 64'(first_low), 64'd656);
    expect_eq("def_hs_last", 64'(last_low), 64'd751);
    expect_eq("def_line_pix", 64'(pv_cnt), 64'd640);

    // reset timing, two full frames
    run(260);
    settle();
    expect_eq("frames_done", 64'(fr_cnt), 64'd2);
    check_frame("def_frame", 128, 32, 8, 16'hE3FF, 16'h009F);

    // mid-frame legal config, applied only after the current frame
    tick(1'b1, 1'b1, C1);
    settle();
    expect_eq("cfg_ready_drop", 64'(o_cfg_ready), 64'd0);
    run(300);
    settle();
    check_frame("c1_frame", 48, 12, 6, 16'h0060, 16'h0010);

    // illegal config: rejected, timing unchanged
    tick(1'b1, 1'b1, BAD);
    settle();
    expect_eq("bad_err_pulse", 64'(o_cfg_err), 64'd1);
    expect_eq("bad_ready", 64'(o_cfg_ready), 64'd1);
    run(100);
    settle();
    expect_eq("bad_err_count", 64'(err_cnt), 64'd1);
    check_frame("after_bad", 48, 12, 6, 16'h0060, 16'h0010);

    // clock-enable freeze at col 3
    for (int k = 0; k < 20 && m_h != 3; k++) tick(1'b1, 1'b0, C1);
    tick(1'b1, 1'b0, C1);
    repeat (5) tick(1'b0, 1'b0, C1);
    settle();
    expect_eq("freeze_col", 64'(o_col), 64'd3);
    tick(1'b1, 1'b0, C1);
    settle();
    expect_eq("resume_col", 64'(o_col), 64'd4);
    run(100);
    settle();
    check_frame("after_freeze", 48, 12, 6, 16'h0060, 16'h0010);

    // transfer on the last pixel of a frame: one more old frame first
    run_until(7, 5);
    tick(1'b1, 1'b1, C2);
    run(49);
    settle();
    expect_eq("extra_old_cycles", 64'(fin_cyc), 64'd48);
    expect_eq("extra_old_pix", 64'(fin_pv), 64'd12);
    run(81);
    settle();
    check_frame("c2_frame", 40, 10, 5, 16'h00BF, 16'h0017);

    // async reset at (2,2) with a config pending
    run_until(0, 0);
    tick(1'b1, 1'b1, C1);
    run_until(2, 2);
    tick(1'b1, 1'b0, C1);
    settle();
    expect_eq("pre_reset_pos", 64'({o_row, o_col}), 64'({12'd2, 12'd2}));
    expect_eq("pre_reset_pending", 64'(o_cfg_ready), 64'd0);
    #1;
    i_en = 1'b0; i_cfg_valid = 1'b0; rst = 1'b1;
    #1;
    expect_eq("async_reset", 64'(pk(o_col, o_row, o_pix_valid, o_hsync, o_vsync, o_sol, o_sof,
                                    o_eof, o_cfg_err, o_cfg_ready)), 64'(RST_VEC));
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(260);
    settle();
    expect_eq("post_reset_frames", 64'(fr_cnt), 64'd2);
    check_frame("post_reset", 128, 32, 8, 16'hE3FF, 16'h009F);
    expect_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    repeat (2) @(posedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised, runtime-reconfigurable VGA/video timing generator.
- Produces pixel coordinates, pixel-valid, HSYNC/VSYNC and line/frame markers.
- Drives the pixel pipeline and VGA output pins.
- Adds three things over a fixed 640x480 generator: programmable porch/pulse/active sizes, programmable sync polarity, and a clock enable.
- New timing is loaded through a valid/ready handshake and takes effect only at a frame boundary, so frames are never torn.

Parameters:
- CNT_W, 12, width of the horizontal/vertical counters and of all config fields.
- DEF_H_ACTIVE, 640, reset horizontal active pixels.
- DEF_H_FP, 16, reset horizontal front porch.
- DEF_H_SYNC, 96, reset horizontal sync pulse width.
- DEF_H_BP, 48, reset horizontal back porch.
- DEF_V_ACTIVE, 480, reset vertical active lines.
- DEF_V_FP, 10, reset vertical front porch.
- DEF_V_SYNC, 2, reset vertical sync width.
- DEF_V_BP, 29, reset vertical back porch.
- DEF_HS_POL, 0, reset HSYNC active level.
- DEF_VS_POL, 0, reset VSYNC active level.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-high reset.
- i_en, in, 1, advance timing when 1; hold all state when 0.
- i_cfg_valid, in, 1, new configuration offered.
- o_cfg_ready, out, 1, configuration can be accepted.
- i_cfg, in, timing_cfg_t (8*CNT_W+2), h/v active, fp, sync, bp, plus hs_pol and vs_pol.
- o_cfg_err, out, 1, one-cycle pulse: offered configuration rejected.
- o_pix_valid, out, 1, current coordinate is inside the active area.
- o_col, out, CNT_W, horizontal position.
- o_row, out, CNT_W, vertical position.
- o_hsync, out, 1, HSYNC at the programmed polarity.
- o_vsync, out, 1, VSYNC at the programmed polarity.
- o_sol, out, 1, start of line (col 0).
- o_sof, out, 1, start of frame (col 0, row 0).
- o_eof, out, 1, last pixel of the frame.

Behaviour:
- Reset:
  - hcnt = vcnt = 0; active config = DEF_* values; pending flag cleared; o_cfg_ready = 1.
  - All outputs registered and cleared: o_col = o_row = 0; o_pix_valid, o_sol, o_sof, o_eof, o_cfg_err = 0.
  - o_hsync = ~DEF_HS_POL; o_vsync = ~DEF_VS_POL (inactive).
- Totals: h_total = h_active+h_fp+h_sync+h_bp; v_total likewise; both computed at CNT_W+2 bits.
- Counting, only when i_en = 1:
  - hcnt runs 0..h_total-1, then wraps to 0.
  - vcnt increments when hcnt wraps; it wraps to 0 when vcnt = v_total-1 and hcnt = h_total-1.
  - When i_en = 0, counters, outputs and the pending config all hold.
- Decode, on the current counter values:
  - pix_valid = (hcnt < h_active) && (vcnt < v_active).
  - hs_act = hcnt in [h_active+h_fp, h_active+h_fp+h_sync-1].
  - vs_act = vcnt in [v_active+v_fp, v_active+v_fp+v_sync-1]; it changes only when hcnt returns to 0.
  - sol = (hcnt == 0); sof = sol && (vcnt == 0); eof = last hcnt of the last vcnt.
- Output latency:
  - Every output is registered from the decode, giving exactly 1 cycle latency.
  - All outputs are mutually aligned: o_col and o_row equal the counters of the previous enabled cycle.
  - o_hsync = hs_act ? hs_pol : ~hs_pol; o_vsync the same with vs_act and vs_pol.
- Config handshake:
  - Transfer occurs when i_cfg_valid && o_cfg_ready.
  - A legal config is latched into the pending register, the pending flag is set and o_cfg_ready drops to 0.
  - Illegal means any field = 0, or h_total or v_total > 2^CNT_W. An illegal config is dropped, o_cfg_err pulses 1 cycle, and o_cfg_ready stays 1.
- Apply:
  - Applies on the enabled cycle where hcnt = h_total-1, vcnt = v_total-1 and pending = 1.
  - On that edge the active config takes the pending value, the counters wrap to 0, the pending flag clears, and o_cfg_ready returns to 1 on the next cycle.
  - A transfer in that same cycle is not applied at this boundary; it applies at the next frame end.
- Polarity change takes effect with the new frame's first output (row 0, col 0).
- Reset mid-frame or with a config pending: pending is discarded, DEF_* values restored, outputs return to reset values immediately (asynchronous).
- i_en = 0 while a transfer is offered: the handshake still completes; only counting and apply are gated.

Decomposition:
- Package video_timing_pkg:
  - timing_cfg_t packed struct (8 CNT_W-wide fields plus 2 polarity bits).
  - DEF_CFG constant.
  - Function cfg_legal().
- Sub-module timing_axis_cnt, instantiated twice (horizontal and vertical):
  - Inputs: step enable, active/fp/sync/bp.
  - Outputs: count, wrap, active, sync-window flags.

Test Plan:
1. Reset defaults, i_en = 1, run 2 frames:
   - o_hsync low for cols 656..751 of each line; 800 cycles per line.
   - o_vsync low for rows 490..491; 521 lines per frame.
   - o_pix_valid count = 307200 per frame; o_sof once per 416800 cycles.
2. Offer cfg {h 4/1/2/1, v 3/1/1/1, hs_pol = 1, vs_pol = 1} mid-frame:
   - o_cfg_ready = 0 until the default frame's o_eof.
   - Next frame: 8-cycle lines; o_hsync high at cols 5..6; 6 lines; o_vsync high on row 4; 12 valid pixels per frame.
3. Offer a cfg with h_sync = 0:
   - o_cfg_err pulses once; o_cfg_ready stays 1; timing unchanged.
4. Small cfg running; toggle i_en = 0 for 5 cycles at col 3:
   - All outputs frozen for 5 cycles; the sequence resumes at col 4 with no skipped or duplicated coordinate.
5. Transfer a cfg in the same cycle as o_eof's source cycle:
   - The old timing runs one more full frame; the new timing starts at the following frame.
6. Assert rst at row 2, col 2 with a config pending:
   - Outputs go to reset values immediately; after release, default 800x521 timing resumes from (0,0); o_cfg_ready = 1.
